// File: rtl/flash_pkg.sv
// Shared definitions for the flash page buffer: controller states, erased fill, width helper.
package flash_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_PROG = 2'd2,
    ST_DONE = 2'd3
  } fpb_state_e;

  // Erased flash reads back as all ones.
  localparam bit FILL_ERASED_BIT = 1'b1;

  function automatic int unsigned fpb_bw(input int unsigned nbuf);
    return (nbuf <= 1) ? 1 : $clog2(nbuf);
  endfunction

endpackage

// File: rtl/fpb_ram.sv
// Page buffer storage: one write port, registered host and program read ports (negedge sck).
module fpb_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WORDS  = 512,
  parameter int unsigned TW     = 9
) (
  input  logic              sck,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [TW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              hre_i,
  input  logic [TW-1:0]     haddr_i,
  output logic [DATA_W-1:0] hrdata_o,
  input  logic              pre_i,
  input  logic [TW-1:0]     paddr_i,
  output logic [DATA_W-1:0] prdata_o
);

  logic [DATA_W-1:0] mem_q [WORDS];
  logic [DATA_W-1:0] hrd_q, prd_q;

  // Array has no reset so contents survive rst_n; only INIT rewrites them.
  always_ff @(negedge sck) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(negedge sck) begin
    if (!rst_n) begin
      hrd_q <= '0;
      prd_q <= '0;
    end else begin
      if (hre_i) hrd_q <= mem_q[haddr_i];
      if (pre_i) prd_q <= mem_q[paddr_i];
    end
  end

  assign hrdata_o = hrd_q;
  assign prdata_o = prd_q;

endmodule

// File: rtl/flash_page_buffer.sv
// Multi-page flash program buffer: host load/read port plus a streaming drain to memory.
module flash_page_buffer
  import flash_pkg::*;
#(
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       DEPTH  = 256,
  parameter int unsigned       NBUF   = 2,
  parameter logic [DATA_W-1:0] FILL   = {DATA_W{FILL_ERASED_BIT}},
  localparam int unsigned      AW     = $clog2(DEPTH),
  localparam int unsigned      BW     = fpb_bw(NBUF)
) (
  input  logic              sck,
  input  logic              rst_n,
  input  logic [BW-1:0]     host_sel,
  input  logic              addr_ld,
  input  logic [AW-1:0]     addr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  input  logic              prog_start,
  input  logic [BW-1:0]     prog_sel,
  input  logic [AW-1:0]     prog_base,
  input  logic [AW:0]       prog_len,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_data,
  output logic [AW-1:0]     mem_offset,
  output logic              mem_last,
  output logic              init_done,
  output logic              prog_busy,
  output logic              err_conflict
);

  localparam int unsigned TW     = BW + AW;
  localparam int unsigned NWORDS = NBUF * DEPTH;

  fpb_state_e        state_q, state_d;
  logic [TW-1:0]     init_q, init_d;
  logic [AW-1:0]     hptr_q, hptr_d, off_q, off_d, hptr_eff;
  logic [AW:0]       rem_q, rem_d;
  logic [BW-1:0]     psel_q, psel_d;
  logic              dvld_q, err_q, err_d;
  logic              host_act, busy, conflict, we, pre_en;
  logic [TW-1:0]     waddr, haddr, paddr;
  logic [DATA_W-1:0] wdata;

  always_comb begin
    state_d  = state_q;
    init_d   = init_q;
    off_d    = off_q;
    rem_d    = rem_q;
    psel_d   = psel_q;
    pre_en   = 1'b0;
    paddr    = {psel_q, off_q};
    host_act = (state_q != ST_INIT);
    busy     = (state_q == ST_PROG) || (state_q == ST_DONE);
    hptr_eff = addr_ld ? addr : hptr_q;
    haddr    = {host_sel, hptr_eff};
    conflict = host_act && wr_en && busy && (host_sel == psel_q);
    err_d    = err_q | conflict;
    hptr_d   = hptr_q;
    if (host_act) begin
      if (wr_en || rd_en) hptr_d = hptr_eff + AW'(1);
      else if (addr_ld)   hptr_d = addr;
    end
    we    = 1'b0;
    waddr = haddr;
    wdata = din;
    case (state_q)
      ST_INIT: begin
        we     = 1'b1;
        waddr  = init_q;
        wdata  = FILL;
        init_d = init_q + TW'(1);
        if (init_q == TW'(NWORDS - 1)) begin
          init_d  = '0;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        we = wr_en;
        if (prog_start) begin
          psel_d  = prog_sel;
          off_d   = prog_base;
          rem_d   = (prog_len == '0) ? (AW+1)'(DEPTH) : prog_len;
          pre_en  = 1'b1;
          paddr   = {prog_sel, prog_base};
          state_d = ST_PROG;
        end
      end
      ST_PROG: begin
        we = wr_en && !conflict;
        // Next word is prefetched on the accepting edge so mem_data holds while stalled.
        if (mem_ready) begin
          if (rem_q == (AW+1)'(1)) begin
            state_d = ST_DONE;
          end else begin
            off_d  = off_q + AW'(1);
            rem_d  = rem_q - (AW+1)'(1);
            pre_en = 1'b1;
            paddr  = {psel_q, off_q + AW'(1)};
          end
        end
      end
      default: begin
        we      = wr_en && !conflict;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(negedge sck) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      init_q  <= '0;
      hptr_q  <= '0;
      off_q   <= '0;
      rem_q   <= '0;
      psel_q  <= '0;
      dvld_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      hptr_q  <= hptr_d;
      off_q   <= off_d;
      rem_q   <= rem_d;
      psel_q  <= psel_d;
      dvld_q  <= host_act && rd_en;
      err_q   <= err_d;
    end
  end

  fpb_ram #(
    .DATA_W (DATA_W),
    .WORDS  (NWORDS),
    .TW     (TW)
  ) u_ram (
    .sck      (sck),
    .rst_n    (rst_n),
    .we_i     (we && rst_n),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .hre_i    (host_act && rd_en),
    .haddr_i  (haddr),
    .hrdata_o (dout),
    .pre_i    (pre_en),
    .paddr_i  (paddr),
    .prdata_o (mem_data)
  );

  assign dout_vld     = dvld_q;
  assign mem_valid    = (state_q == ST_PROG);
  assign mem_last     = (state_q == ST_PROG) && (rem_q == (AW+1)'(1));
  assign mem_offset   = off_q;
  assign init_done    = (state_q != ST_INIT);
  assign prog_busy    = (state_q == ST_PROG) || (state_q == ST_DONE);
  assign err_conflict = err_q;

endmodule

// File: tb/tb_flash_page_buffer.sv
// Bench for flash_page_buffer: directed scenarios plus randomized host/drain traffic vs. a page-array model.
module tb_flash_page_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 256;
  localparam int NBUF  = 2;
  localparam int AW    = 8;
  localparam int BW    = 1;
  localparam int NW    = NBUF * DEPTH;

  logic          sck = 1'b0;
  logic          rst_n;
  logic [BW-1:0] host_sel, prog_sel;
  logic          addr_ld, wr_en, rd_en, prog_start, mem_ready;
  logic [AW-1:0] addr, prog_base;
  logic [DW-1:0] din;
  logic [AW:0]   prog_len;
  logic [DW-1:0] dout, mem_data;
  logic [AW-1:0] mem_offset;
  logic          dout_vld, mem_valid, mem_last, init_done, prog_busy, err_conflict;

  always #5 sck = ~sck;

  flash_page_buffer #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .NBUF   (NBUF)
  ) dut (
    .sck          (sck),
    .rst_n        (rst_n),
    .host_sel     (host_sel),
    .addr_ld      (addr_ld),
    .addr         (addr),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .dout_vld     (dout_vld),
    .prog_start   (prog_start),
    .prog_sel     (prog_sel),
    .prog_base    (prog_base),
    .prog_len     (prog_len),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_data     (mem_data),
    .mem_offset   (mem_offset),
    .mem_last     (mem_last),
    .init_done    (init_done),
    .prog_busy    (prog_busy),
    .err_conflict (err_conflict)
  );

  typedef struct {
    int off;
    int data;
    bit last;
  } beat_t;

  beat_t pq[$];
  int    mmem[NW];
  int    mptr, mdout, busy_sel;
  bit    mvld, merr, in_done;
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge sck);
    @(posedge sck);
    #1;
  endtask

  task automatic clr_in();
    host_sel = '0; addr_ld = 0; addr = '0; wr_en = 0; din = '0; rd_en = 0;
    prog_start = 0; prog_sel = '0; prog_base = '0; prog_len = '0; mem_ready = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NW; i++) mmem[i] = 'hFF;
    mptr = 0; mdout = 0; mvld = 0; merr = 0; in_done = 0; busy_sel = -1;
    pq.delete();
  endtask

  // One clock of the reference: check drain outputs, advance model with current inputs, clock, check host outputs.
  task automatic cycle();
    bit busy, conflict;
    int eff, idx, len;
    busy = (pq.size() > 0) || in_done;
    chk("mem_valid", 32'(mem_valid), 32'(pq.size() > 0));
    if (pq.size() > 0) begin
      chk("mem_offset", 32'(mem_offset), pq[0].off);
      chk("mem_data", 32'(mem_data), pq[0].data);
      chk("mem_last", 32'(mem_last), 32'(pq[0].last));
    end
    chk("prog_busy", 32'(prog_busy), 32'(busy));
    conflict = wr_en && busy && (int'(host_sel) == busy_sel);
    eff = addr_ld ? int'(addr) : mptr;
    idx = int'(host_sel) * DEPTH + eff;
    mvld = rd_en;
    if (rd_en) mdout = mmem[idx];
    if (wr_en) begin
      if (conflict) merr = 1;
      else mmem[idx] = int'(din);
    end
    if (wr_en || rd_en) mptr = (eff + 1) % DEPTH;
    else if (addr_ld)   mptr = int'(addr);
    if (pq.size() > 0) begin
      if (mem_ready) begin
        pq.delete(0);
        if (pq.size() == 0) in_done = 1;
      end
    end else if (in_done) begin
      in_done = 0;
    end else if (prog_start) begin
      len = (prog_len == 0) ? DEPTH : int'(prog_len);
      busy_sel = int'(prog_sel);
      for (int k = 0; k < len; k++) begin
        beat_t b;
        b.off  = (int'(prog_base) + k) % DEPTH;
        b.data = mmem[busy_sel * DEPTH + b.off];
        b.last = (k == len - 1);
        pq.push_back(b);
      end
    end
    tick();
    chk("dout_vld", 32'(dout_vld), 32'(mvld));
    chk("dout", 32'(dout), mdout);
    chk("err_conflict", 32'(err_conflict), 32'(merr));
    chk("init_done_hold", 32'(init_done), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_init_done"}, 32'(init_done), 0);
    chk({tag, "_mem_valid"}, 32'(mem_valid), 0);
    chk({tag, "_mem_last"}, 32'(mem_last), 0);
    chk({tag, "_mem_offset"}, 32'(mem_offset), 0);
    chk({tag, "_mem_data"}, 32'(mem_data), 0);
    chk({tag, "_prog_busy"}, 32'(prog_busy), 0);
    chk({tag, "_dout"}, 32'(dout), 0);
    chk({tag, "_dout_vld"}, 32'(dout_vld), 0);
    chk({tag, "_err"}, 32'(err_conflict), 0);
  endtask

  int rdy[5] = '{1, 0, 0, 1, 1};
  int r;

  initial begin
    clr_in();
    model_reset();
    rst_n = 0;
    #1;
    tick();
    tick();
    check_reset_outputs("rst");
    rst_n = 1;
    repeat (NW - 1) tick();
    chk("init_not_yet", 32'(init_done), 0);
    tick();
    chk("init_done", 32'(init_done), 1);

    // Erased read of buffer 0 word 0
    addr_ld = 1; addr = 8'h00; rd_en = 1;
    cycle();
    chk("erased_read", 32'(dout), 32'hFF);
    clr_in();
    cycle();

    // Load 0xFE and write across the page wrap, then read back
    addr_ld = 1; addr = 8'hFE; wr_en = 1; din = 8'hA1;
    cycle();
    addr_ld = 0; din = 8'hA2;
    cycle();
    din = 8'hA3;
    cycle();
    clr_in();
    addr_ld = 1; addr = 8'hFE; rd_en = 1;
    cycle();
    chk("rb_FE", 32'(dout), 32'hA1);
    addr_ld = 0;
    cycle();
    chk("rb_FF", 32'(dout), 32'hA2);
    cycle();
    chk("rb_00", 32'(dout), 32'hA3);
    clr_in();

    // Drain buf0 from 0xFE, 3 words, with a two-cycle stall on word 1
    prog_start = 1; prog_sel = 0; prog_base = 8'hFE; prog_len = 9'd3;
    cycle();
    clr_in();
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy[i][0];
      if (i == 1 || i == 2) begin
        chk("stall_offset", 32'(mem_offset), 32'hFF);
        chk("stall_data", 32'(mem_data), 32'hA2);
        chk("stall_last", 32'(mem_last), 0);
      end
      if (i == 4) chk("last_offset", 32'(mem_offset), 32'h00);
      cycle();
    end
    clr_in();
    chk("done_valid", 32'(mem_valid), 0);
    chk("done_busy", 32'(prog_busy), 1);
    cycle();
    cycle();

    // Conflicting host write during drain of buf0, legal write to buf1
    prog_start = 1; prog_sel = 0; prog_base = 8'h10; prog_len = 9'd4;
    cycle();
    clr_in();
    chk("err_before", 32'(err_conflict), 0);
    host_sel = 0; addr_ld = 1; addr = 8'h10; wr_en = 1; din = 8'h55;
    cycle();
    chk("err_set", 32'(err_conflict), 1);
    host_sel = 1; addr_ld = 1; addr = 8'h10; wr_en = 1; din = 8'h66;
    cycle();
    clr_in();
    mem_ready = 1;
    for (int i = 0; i < 10; i++) cycle();
    clr_in();
    host_sel = 0; addr_ld = 1; addr = 8'h10; rd_en = 1;
    cycle();
    chk("conflict_kept", 32'(dout), 32'hFF);
    host_sel = 1;
    cycle();
    chk("buf1_written", 32'(dout), 32'h66);
    clr_in();

    // Randomized host and drain traffic
    for (int n = 0; n < 1500; n++) begin
      host_sel  = BW'($urandom_range(0, NBUF - 1));
      addr_ld   = ($urandom % 4) == 0;
      addr      = AW'($urandom);
      wr_en     = ($urandom % 2) == 0;
      rd_en     = ($urandom % 2) == 0;
      din       = DW'($urandom);
      mem_ready = ($urandom % 3) != 0;
      prog_start = ($urandom % 6) == 0;
      prog_sel  = BW'($urandom_range(0, NBUF - 1));
      prog_base = AW'($urandom);
      r = $urandom % 12;
      prog_len  = (r == 0) ? 9'd0 : (r == 1) ? 9'd256 : (AW+1)'($urandom_range(1, 8));
      if (prog_start && pq.size() == 0 && !in_done) wr_en = 0;
      cycle();
    end

    // Let any drain finish, then reset in the middle of a new one
    clr_in();
    mem_ready = 1;
    for (int i = 0; i < 600 && (pq.size() > 0 || in_done); i++) cycle();
    clr_in();
    prog_start = 1; prog_sel = 0; prog_base = 8'h20; prog_len = 9'd8;
    cycle();
    clr_in();
    cycle();
    cycle();
    chk("midprog_valid", 32'(mem_valid), 1);
    rst_n = 0;
    tick();
    check_reset_outputs("abort");
    model_reset();
    rst_n = 1;
    repeat (NW) tick();
    chk("reinit_done", 32'(init_done), 1);
    host_sel = 0; addr_ld = 1; addr = 8'hFE; rd_en = 1;
    cycle();
    chk("refill_buf0", 32'(dout), 32'hFF);
    host_sel = 1; addr = 8'h10;
    cycle();
    chk("refill_buf1", 32'(dout), 32'hFF);
    clr_in();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
